// File: rtl/pmips_l1.sv
// pmips_l1: five-stage pipelined 16-bit PMIPS core (IF/ID/EX/MEM/WB) with
// operand forwarding, load-use stall and branch/jump flush.
module pmips_l1 (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] imemaddr,
  input  logic [15:0] imemrdata,
  output logic [15:0] dmemaddr,
  output logic [15:0] dmemwdata,
  output logic        dmemwrite,
  output logic        dmemread,
  input  logic [15:0] dmemrdata,
  output logic [15:0] aluresult,
  output logic [15:0] debug,
  output logic        stall,
  output logic [15:0] debug2,
  output logic [15:0] debug3,
  output logic [15:0] debug4,
  output logic        debug5,
  output logic [15:0] debug6,
  output logic [15:0] debug7
);
  localparam int unsigned W    = 16;
  localparam int unsigned RW   = 3;
  localparam int unsigned NREG = 8;
  localparam logic [2:0] OP_R = 3'd0, OP_ADDI = 3'd1, OP_J = 3'd2, OP_BEQ = 3'd4;
  localparam logic [2:0] OP_BNE = 3'd5, OP_LW = 3'd6, OP_SW = 3'd7;

  // Register-writing instruction with a non-zero destination.
  function automatic logic f_wr(input logic [2:0] op, input logic [3:0] fn,
                                input logic [RW-1:0] dst);
    logic w;
    case (op)
      OP_R:           w = (fn == 4'd0) || (fn == 4'd1) || (fn == 4'd4) ||
                          (fn == 4'd5) || (fn == 4'd7);
      OP_ADDI, OP_LW: w = 1'b1;
      default:        w = 1'b0;
    endcase
    return w && (dst != '0);
  endfunction

  function automatic logic [RW-1:0] f_dst(input logic [2:0] op, input logic [RW-1:0] rd,
                                          input logic [RW-1:0] rt);
    return (op == OP_R) ? rd : rt;
  endfunction

  logic [W-1:0]  r_pc, r_ifid_ir, r_ifid_pc2;
  logic [W-1:0]  r_idex_ir, r_idex_pc2, r_idex_a, r_idex_b;
  logic [W-1:0]  r_exmem_ir, r_exmem_alu, r_exmem_b;
  logic [W-1:0]  r_memwb_alu, r_memwb_ld;
  logic          r_memwb_we, r_memwb_isld;
  logic [RW-1:0] r_memwb_dst;
  logic [W-1:0]  r_rf [NREG];

  logic [W-1:0]  w_wb_data, w_id_a, w_id_b, w_jmp_tgt;
  logic [RW-1:0] w_id_rs, w_id_rt, w_ex_rs, w_ex_rt, w_exmem_dst;
  logic [2:0]    w_ex_op, w_exmem_op;
  logic          w_id_jump, w_exmem_we, w_br_taken, w_stall;
  logic [W-1:0]  w_ex_a, w_ex_b, w_ex_imm, w_alu, w_br_tgt;

  // Write-back data and ID-stage register read with same-cycle WB bypass.
  assign w_wb_data = r_memwb_isld ? r_memwb_ld : r_memwb_alu;
  assign w_id_rs   = r_ifid_ir[12:10];
  assign w_id_rt   = r_ifid_ir[9:7];
  assign w_id_a    = (r_memwb_we && (r_memwb_dst == w_id_rs)) ? w_wb_data : r_rf[w_id_rs];
  assign w_id_b    = (r_memwb_we && (r_memwb_dst == w_id_rt)) ? w_wb_data : r_rf[w_id_rt];
  assign w_id_jump = (r_ifid_ir[15:13] == OP_J);
  assign w_jmp_tgt = {r_ifid_pc2[15:14], r_ifid_ir[12:0], 1'b0};

  assign w_ex_op     = r_idex_ir[15:13];
  assign w_ex_rs     = r_idex_ir[12:10];
  assign w_ex_rt     = r_idex_ir[9:7];
  assign w_ex_imm    = {{(W-7){r_idex_ir[6]}}, r_idex_ir[6:0]};
  assign w_exmem_op  = r_exmem_ir[15:13];
  assign w_exmem_dst = f_dst(w_exmem_op, r_exmem_ir[6:4], r_exmem_ir[9:7]);
  assign w_exmem_we  = f_wr(w_exmem_op, r_exmem_ir[3:0], w_exmem_dst);

  // Operand forwarding: the younger producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    w_ex_a = r_idex_a;
    w_ex_b = r_idex_b;
    if (w_exmem_we && (w_exmem_dst == w_ex_rs))     w_ex_a = r_exmem_alu;
    else if (r_memwb_we && (r_memwb_dst == w_ex_rs)) w_ex_a = w_wb_data;
    if (w_exmem_we && (w_exmem_dst == w_ex_rt))     w_ex_b = r_exmem_alu;
    else if (r_memwb_we && (r_memwb_dst == w_ex_rt)) w_ex_b = w_wb_data;
  end

  always_comb begin
    w_alu = '0;
    case (w_ex_op)
      OP_R: begin
        case (r_idex_ir[3:0])
          4'd0:    w_alu = w_ex_a + w_ex_b;
          4'd1:    w_alu = w_ex_a - w_ex_b;
          4'd4:    w_alu = w_ex_a & w_ex_b;
          4'd5:    w_alu = w_ex_a | w_ex_b;
          4'd7:    w_alu = W'($signed(w_ex_a) < $signed(w_ex_b));
          default: w_alu = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: w_alu = w_ex_a + w_ex_imm;
      OP_BEQ, OP_BNE:        w_alu = w_ex_a - w_ex_b;
      default:               w_alu = '0;
    endcase
  end

  assign w_br_taken = ((w_ex_op == OP_BEQ) && (w_ex_a == w_ex_b)) ||
                      ((w_ex_op == OP_BNE) && (w_ex_a != w_ex_b));
  assign w_br_tgt   = r_idex_pc2 + {w_ex_imm[W-2:0], 1'b0};
  assign w_stall    = (w_ex_op == OP_LW) && ((w_ex_rt == w_id_rs) || (w_ex_rt == w_id_rt));

  // Pipeline registers; taken branch outranks stall, stall outranks jump.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc         <= '0;
      r_ifid_ir    <= '0;
      r_ifid_pc2   <= '0;
      r_idex_ir    <= '0;
      r_idex_pc2   <= '0;
      r_idex_a     <= '0;
      r_idex_b     <= '0;
      r_exmem_ir   <= '0;
      r_exmem_alu  <= '0;
      r_exmem_b    <= '0;
      r_memwb_alu  <= '0;
      r_memwb_ld   <= '0;
      r_memwb_we   <= 1'b0;
      r_memwb_isld <= 1'b0;
      r_memwb_dst  <= '0;
    end else begin
      r_exmem_ir   <= r_idex_ir;
      r_exmem_alu  <= w_alu;
      r_exmem_b    <= w_ex_b;
      r_memwb_alu  <= r_exmem_alu;
      r_memwb_ld   <= dmemrdata;
      r_memwb_we   <= w_exmem_we;
      r_memwb_isld <= (w_exmem_op == OP_LW);
      r_memwb_dst  <= w_exmem_dst;
      if (w_br_taken || w_stall) begin
        r_idex_ir  <= '0;
        r_idex_pc2 <= '0;
        r_idex_a   <= '0;
        r_idex_b   <= '0;
        if (w_br_taken) begin
          r_pc       <= w_br_tgt;
          r_ifid_ir  <= '0;
          r_ifid_pc2 <= '0;
        end
      end else begin
        r_pc       <= w_id_jump ? w_jmp_tgt : (r_pc + W'(2));
        r_ifid_ir  <= w_id_jump ? '0 : imemrdata;
        r_ifid_pc2 <= r_pc + W'(2);
        r_idex_ir  <= r_ifid_ir;
        r_idex_pc2 <= r_ifid_pc2;
        r_idex_a   <= w_id_a;
        r_idex_b   <= w_id_b;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (r_memwb_we) begin
      r_rf[r_memwb_dst] <= w_wb_data;
    end
  end

  assign imemaddr  = r_pc;
  assign dmemaddr  = r_exmem_alu;
  assign dmemwdata = r_exmem_b;
  assign dmemwrite = (w_exmem_op == OP_SW);
  assign dmemread  = (w_exmem_op == OP_LW);
  assign aluresult = w_alu;
  assign debug     = r_memwb_alu;
  assign stall     = w_stall;
  assign debug2    = r_ifid_ir;
  assign debug3    = r_idex_ir;
  assign debug4    = r_exmem_ir;
  assign debug5    = r_memwb_we;
  assign debug6    = w_wb_data;
  assign debug7    = r_exmem_alu;
endmodule

// File: tb/tb_pmips_l1.sv
// Bench for pmips_l1: directed pipeline-timing scenarios plus random programs
// checked against an instruction-level (non-pipelined) reference model.
module tb_pmips_l1;
  logic        clock, reset;
  logic [15:0] imemaddr, imemrdata, dmemaddr, dmemwdata, dmemrdata, aluresult;
  logic [15:0] debug, debug2, debug3, debug4, debug6, debug7;
  logic        dmemwrite, dmemread, stall, debug5;

  logic [15:0] imem  [0:255];
  logic [15:0] dmem  [0:63];
  logic [15:0] dinit [0:63];
  logic [15:0] wq[$];
  logic [31:0] sq[$];
  logic [15:0] exp_w[$];
  logic [31:0] exp_s[$];
  int n_cmp = 0;
  int n_fail = 0;

  pmips_l1 dut (
    .clock(clock), .reset(reset), .imemaddr(imemaddr), .imemrdata(imemrdata),
    .dmemaddr(dmemaddr), .dmemwdata(dmemwdata), .dmemwrite(dmemwrite),
    .dmemread(dmemread), .dmemrdata(dmemrdata), .aluresult(aluresult),
    .debug(debug), .stall(stall), .debug2(debug2), .debug3(debug3),
    .debug4(debug4), .debug5(debug5), .debug6(debug6), .debug7(debug7)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign imemrdata = imem[imemaddr[8:1]];
  assign dmemrdata = dmem[dmemaddr[6:1]];

  // Data memory: reloaded from dinit while reset is low.
  always @(posedge clock) begin
    if (!reset) dmem <= dinit;
    else if (dmemwrite) dmem[dmemaddr[6:1]] <= dmemwdata;
  end

  // Retirement monitor: register write-backs and stores, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      wq.delete();
      sq.delete();
    end else begin
      if (debug5) wq.push_back(debug6);
      if (dmemwrite) sq.push_back({dmemaddr, dmemwdata});
    end
  end

  function automatic logic [15:0] e_r(input int rs, input int rt, input int rd, input int fn);
    return {3'd0, 3'(rs), 3'(rt), 3'(rd), 4'(fn)};
  endfunction
  function automatic logic [15:0] e_i(input int op, input int rs, input int rt, input int imm);
    return {3'(op), 3'(rs), 3'(rt), 7'(imm)};
  endfunction
  function automatic logic [15:0] e_j(input int a);
    return {3'd2, 13'(a)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = '0;
    for (int i = 0; i < 64; i++) dinit[i] = 16'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic load_basic();
    clear_imem();
    imem[0] = e_i(1, 0, 1, 5);
    imem[1] = e_i(1, 0, 2, 3);
    imem[2] = e_r(1, 2, 3, 0);
  endtask

  task automatic test_reset();
    clear_imem();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (imemaddr !== 16'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0000", imemaddr); end
    n_cmp++; if ({stall, dmemwrite, dmemread, debug5} !== 4'b0) begin n_fail++; $display("FAIL rst_ctl: got %b want 0000", {stall, dmemwrite, dmemread, debug5}); end
    n_cmp++; if ({debug2, debug3, debug4, debug6, debug7, debug} !== 96'h0) begin n_fail++; $display("FAIL rst_dbg: got %h want 0", {debug2, debug3, debug4, debug6, debug7, debug}); end
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if ({imemaddr, dmemwrite, dmemread} !== 18'h0) begin n_fail++; $display("FAIL rst_hold: got %h want 0", {imemaddr, dmemwrite, dmemread}); end
    @(negedge clock);
    #2 reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (imemaddr !== 16'(2 * k) || stall !== 1'b0) begin n_fail++; $display("FAIL fetch_seq: cycle %0d pc %h stall %b want pc %h stall 0", k, imemaddr, stall, 16'(2 * k)); end
    end
  endtask

  task automatic test_forward();
    bit found = 0;
    load_basic();
    do_reset();
    for (int k = 0; k < 20 && !found; k++) begin tick(); found = (debug3 === imem[2]); end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL fwd_wait: add never reached EX"); end
    n_cmp++; if (aluresult !== 16'd8) begin n_fail++; $display("FAIL fwd_alu: got %h want 0008", aluresult); end
    tick();
    n_cmp++; if (debug7 !== 16'd8 || debug4 !== imem[2]) begin n_fail++; $display("FAIL fwd_mem: got %h/%h want 0008/%h", debug7, debug4, imem[2]); end
    tick();
    n_cmp++; if (debug5 !== 1'b1 || debug6 !== 16'd8 || debug !== 16'd8) begin n_fail++; $display("FAIL fwd_wb: got we %b data %h dbg %h want 1/0008/0008", debug5, debug6, debug); end
  endtask

  task automatic test_load_store();
    int nw = 0, nr = 0, ns = 0;
    logic [15:0] wa = '0, wd = '0;
    logic [15:0] ex[$] = '{16'd5, 16'd3, 16'd8, 16'd8, 16'd16};
    load_basic();
    imem[3] = e_i(7, 0, 3, 4);
    imem[4] = e_i(6, 0, 4, 4);
    imem[5] = e_r(4, 4, 5, 0);
    do_reset();
    for (int k = 0; k < 25; k++) begin
      tick();
      if (dmemwrite) begin nw++; wa = dmemaddr; wd = dmemwdata; end
      if (dmemread) nr++;
      if (stall) ns++;
    end
    n_cmp++; if (nw != 1 || wa !== 16'd4 || wd !== 16'd8) begin n_fail++; $display("FAIL sw_strobe: cycles %0d addr %h data %h want 1/0004/0008", nw, wa, wd); end
    n_cmp++; if (nr != 1) begin n_fail++; $display("FAIL lw_strobe: cycles %0d want 1", nr); end
    n_cmp++; if (ns != 1) begin n_fail++; $display("FAIL load_use_stall: cycles %0d want 1", ns); end
    n_cmp++; if (wq.size() != ex.size()) begin n_fail++; $display("FAIL ls_wcount: got %0d want %0d", wq.size(), ex.size()); end
    for (int i = 0; i < ex.size() && i < wq.size(); i++) begin
      n_cmp++; if (wq[i] !== ex[i]) begin n_fail++; $display("FAIL ls_wb[%0d]: got %h want %h", i, wq[i], ex[i]); end
    end
  endtask

  task automatic test_branch(input bit is_bne);
    bit found = 0;
    logic [15:0] ex[$];
    clear_imem();
    imem[0] = e_i(1, 0, 1, 5);
    imem[1] = e_i(is_bne ? 5 : 4, 1, 1, 2);
    imem[2] = e_i(1, 0, 2, 1);
    imem[3] = e_i(1, 0, 3, 2);
    imem[4] = e_i(1, 0, 4, 3);
    if (is_bne) ex = '{16'd5, 16'd1, 16'd2, 16'd3};
    else        ex = '{16'd5, 16'd3};
    do_reset();
    for (int k = 0; k < 20 && !found; k++) begin tick(); found = (debug3 === imem[1]); end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL br_wait: branch never reached EX"); end
    tick();
    n_cmp++; if (imemaddr !== 16'd8) begin n_fail++; $display("FAIL br_pc: bne=%0d got %h want 0008", is_bne, imemaddr); end
    n_cmp++;
    if (!is_bne && (debug2 !== 16'h0 || debug3 !== 16'h0)) begin n_fail++; $display("FAIL br_flush: got %h/%h want 0000/0000", debug2, debug3); end
    else if (is_bne && (debug2 !== imem[3] || debug3 !== imem[2])) begin n_fail++; $display("FAIL bne_noflush: got %h/%h want %h/%h", debug2, debug3, imem[3], imem[2]); end
    repeat (12) tick();
    n_cmp++; if (wq.size() != ex.size()) begin n_fail++; $display("FAIL br_wcount: bne=%0d got %0d want %0d", is_bne, wq.size(), ex.size()); end
    for (int i = 0; i < ex.size() && i < wq.size(); i++) begin
      n_cmp++; if (wq[i] !== ex[i]) begin n_fail++; $display("FAIL br_wb[%0d]: got %h want %h", i, wq[i], ex[i]); end
    end
  endtask

  task automatic test_jump();
    bit found = 0;
    clear_imem();
    imem[0]  = e_j(16'h0010);
    imem[1]  = e_i(1, 0, 1, 7);
    imem[16] = e_i(1, 0, 2, 9);
    do_reset();
    for (int k = 0; k < 10 && !found; k++) begin tick(); found = (debug2 === imem[0]); end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL j_wait: jump never reached ID"); end
    tick();
    n_cmp++; if (imemaddr !== 16'h0020 || debug2 !== 16'h0) begin n_fail++; $display("FAIL j_redirect: pc %h ifid %h want 0020/0000", imemaddr, debug2); end
    tick();
    n_cmp++; if (debug2 !== imem[16]) begin n_fail++; $display("FAIL j_target: ifid %h want %h", debug2, imem[16]); end
    repeat (10) tick();
    n_cmp++; if (wq.size() != 1 || wq[0] !== 16'd9) begin n_fail++; $display("FAIL j_wb: count %0d first %h want 1/0009", wq.size(), (wq.size() > 0) ? wq[0] : 16'hxxxx); end
  endtask

  task automatic test_arith();
    logic [15:0] ex[$] = '{16'd5, 16'd3, 16'hFFFE, 16'd1, 16'd5, 16'd1, 16'd7};
    load_basic();
    imem[2] = e_r(2, 1, 6, 1);
    imem[3] = e_r(6, 0, 7, 7);
    imem[4] = e_i(1, 0, 0, 9);
    imem[5] = e_r(0, 1, 5, 0);
    imem[6] = e_r(1, 2, 4, 4);
    imem[7] = e_r(1, 2, 3, 2);
    imem[8] = e_r(1, 2, 3, 5);
    do_reset();
    repeat (20) tick();
    n_cmp++; if (wq.size() != ex.size()) begin n_fail++; $display("FAIL ar_wcount: got %0d want %0d", wq.size(), ex.size()); end
    for (int i = 0; i < ex.size() && i < wq.size(); i++) begin
      n_cmp++; if (wq[i] !== ex[i]) begin n_fail++; $display("FAIL ar_wb[%0d]: got %h want %h", i, wq[i], ex[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    load_basic();
    imem[3] = e_i(7, 0, 3, 4);
    imem[4] = e_i(6, 0, 4, 4);
    do_reset();
    for (int k = 0; k < 20 && !found; k++) begin tick(); found = (dmemwrite === 1'b1); end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL mid_wait: no store seen"); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({dmemwrite, dmemread, debug5, stall} !== 4'b0 || {imemaddr, debug2, debug3, debug4, debug7} !== 80'h0) begin
      n_fail++; $display("FAIL mid_reset: ctl %b state %h want 0", {dmemwrite, dmemread, debug5, stall}, {imemaddr, debug2, debug3, debug4, debug7});
    end
  endtask

  task automatic gen_prog(input int n);
    int fl[6] = '{0, 1, 4, 5, 7, 3};
    int rs, lim;
    clear_imem();
    for (int i = 0; i < n; i++) begin
      rs  = $urandom_range(0, 7);
      lim = (n - 1 - i > 3) ? 3 : n - 1 - i;
      case ($urandom_range(0, 9))
        0, 1:    imem[i] = e_i(1, rs, $urandom_range(1, 7), $urandom_range(0, 127));
        2, 3, 9: imem[i] = e_r(rs, $urandom_range(0, 7), $urandom_range(0, 7), fl[$urandom_range(0, 5)]);
        4:       imem[i] = e_i(6, 0, $urandom_range(1, 7), 2 * $urandom_range(0, 15));
        5:       imem[i] = e_i(7, 0, $urandom_range(0, 7), 2 * $urandom_range(0, 15));
        6:       imem[i] = e_i($urandom_range(4, 5), rs, $urandom_range(0, 1) ? rs : $urandom_range(0, 7), $urandom_range(0, lim));
        7:       imem[i] = e_j($urandom_range(i + 1, n));
        default: imem[i] = {3'd3, 13'($urandom)};
      endcase
    end
    imem[n] = e_j(n);
  endtask

  // Instruction-at-a-time ISA model: architectural results only, no pipeline.
  task automatic model(input int n);
    logic [15:0] r [0:7];
    logic [15:0] m [0:63];
    logic [15:0] pc, ir, a, b, imm, v, nx, ad;
    bit wr;
    exp_w.delete();
    exp_s.delete();
    for (int i = 0; i < 8; i++) r[i] = '0;
    for (int i = 0; i < 64; i++) m[i] = dinit[i];
    pc = '0;
    for (int step = 0; step < 500 && pc != 16'(2 * n); step++) begin
      ir  = imem[pc[8:1]];
      a   = r[ir[12:10]];
      b   = r[ir[9:7]];
      imm = {{9{ir[6]}}, ir[6:0]};
      ad  = a + imm;
      nx  = pc + 16'd2;
      wr  = 1'b1;
      v   = '0;
      case (ir[15:13])
        3'd0: begin
          case (ir[3:0])
            4'd0: v = a + b;
            4'd1: v = a - b;
            4'd4: v = a & b;
            4'd5: v = a | b;
            4'd7: v = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: wr = 1'b0;
          endcase
          if (wr && ir[6:4] != 3'd0) begin r[ir[6:4]] = v; exp_w.push_back(v); end
        end
        3'd1: if (ir[9:7] != 3'd0) begin r[ir[9:7]] = ad; exp_w.push_back(ad); end
        3'd2: nx = {nx[15:14], ir[12:0], 1'b0};
        3'd4: if (a == b) nx = nx + (imm << 1);
        3'd5: if (a != b) nx = nx + (imm << 1);
        3'd6: if (ir[9:7] != 3'd0) begin r[ir[9:7]] = m[ad[6:1]]; exp_w.push_back(m[ad[6:1]]); end
        3'd7: begin m[ad[6:1]] = b; exp_s.push_back({ad, b}); end
        default: ;
      endcase
      pc = nx;
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 10; p++) begin
      gen_prog(20);
      model(20);
      do_reset();
      repeat (130) tick();
      n_cmp++; if (wq.size() != exp_w.size()) begin n_fail++; $display("FAIL rnd_wcount: prog %0d got %0d want %0d", p, wq.size(), exp_w.size()); end
      for (int i = 0; i < exp_w.size() && i < wq.size(); i++) begin
        n_cmp++; if (wq[i] !== exp_w[i]) begin n_fail++; $display("FAIL rnd_wb: prog %0d idx %0d got %h want %h", p, i, wq[i], exp_w[i]); end
      end
      n_cmp++; if (sq.size() != exp_s.size()) begin n_fail++; $display("FAIL rnd_scount: prog %0d got %0d want %0d", p, sq.size(), exp_s.size()); end
      for (int i = 0; i < exp_s.size() && i < sq.size(); i++) begin
        n_cmp++; if (sq[i] !== exp_s[i]) begin n_fail++; $display("FAIL rnd_store: prog %0d idx %0d got %h want %h", p, i, sq[i], exp_s[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_store();
    test_branch(1'b0);
    test_branch(1'b1);
    test_jump();
    test_arith();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pmips_l1.md
# pmips_l1

Five-stage pipelined 16-bit PMIPS processor core (IF, ID, EX, MEM, WB) with forwarding, load-use stall and branch/jump flush. Fetches from an external combinational instruction memory and accesses an external data/IO memory through address, write-data and read/write strobes. Exposes pipeline state on debug ports for simulation benches and board bring-up.

## Interface
- No parameters.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imemaddr  out  16  PC, byte address
- imemrdata  in  16  instruction at imemaddr, combinational
- dmemaddr  out  16  EX/MEM ALU result
- dmemwdata  out  16  EX/MEM store data (rt)
- dmemwrite  out  1  store strobe, memory writes on rising clock
- dmemread  out  1  load strobe
- dmemrdata  in  16  load data, combinational
- aluresult  out  16  combinational EX-stage ALU output
- debug  out  16  MEM/WB ALU result
- stall  out  1  load-use stall asserted this cycle
- debug2 / debug3 / debug4  out  16  IF/ID, ID/EX, EX/MEM instruction words
- debug5  out  1  WB register-write enable
- debug6  out  16  WB write-back data
- debug7  out  16  EX/MEM ALU result (equals dmemaddr)

## Operation
- 8 registers × 16 bits; $0 reads 0, writes ignored. Fields: op[15:13], rs[12:10], rt[9:7], rd[6:4], funct[3:0], imm7[6:0] sign-extended, jaddr[12:0].
- op 0 R-type: funct 0 add, 1 sub, 4 and, 5 or, 7 slt (signed, result 1/0); other funct = no-op. rd written.
- op 1 addi rt=rs+imm; op 2 j; op 4 beq; op 5 bne; op 6 lw rt=M[rs+imm]; op 7 sw M[rs+imm]=rt; op 3 = no-op.
- Arithmetic modulo 2^16, overflow ignored. Instruction 0x0000 is the NOP.
- PC+2 each fetch. Branch target = PC_branch+2+(imm7<<1). Jump target = {(PC+2)[15:14], jaddr, 1'b0}.
- Register file written on rising clock in WB; a same-cycle read of the register being written returns the new value.
- Forwarding to EX operands: EX/MEM result first, then MEM/WB (load data or ALU); never from $0.
- Load-use: lw in EX whose rt equals rs or rt of the ID instruction -> stall=1 for one cycle: PC and IF/ID hold, bubble (NOP) into ID/EX.
- Jump decoded in ID: PC <- target, IF/ID flushed to NOP (1-cycle penalty).
- Branch resolved in EX: if taken, PC <- target, IF/ID and ID/EX flushed (2-cycle penalty). No delay slots. Branch in EX has priority over a jump in ID and over stall.

## Timing
- reset low (async): PC=0, all pipeline registers NOP with controls 0, registers cleared; imemaddr=0, dmemwrite=dmemread=0, stall=0, debug outputs 0.
- First instruction fetched in the first rising edge after reset releases; its result is written at the end of cycle 5.
- dmemwrite/dmemread are high for exactly the one cycle the instruction is in MEM.
- Reset asserted mid-operation discards all in-flight instructions immediately; no partial register/memory writes after assertion.

## Test plan
- Reset low 2 time units then high -> imemaddr 0, 2, 4, 6… one per cycle; stall=0; all strobes 0 during reset.
- addi $1,$0,5; addi $2,$0,3; add $3,$1,$2 back-to-back -> aluresult 8 in EX of add (forwarded), debug6=8, debug5=1 in its WB.
- sw $3,4($0); lw $4,4($0); add $5,$4,$4 -> dmemwrite=1 with dmemaddr=4, dmemwdata=8; stall=1 exactly one cycle; $5=16.
- beq $1,$1,+2 taken -> two younger instructions become NOP (debug2/debug3 = 0), fetch resumes at branch PC+6; bne same operands -> no flush.
- j to jaddr 0x0010 -> next fetch at 0x0020, one bubble in IF/ID.
- sub $6,$2,$1 -> 0xFFFE; slt $7,$6,$0 -> 1; write to $0 -> $0 still reads 0.
